alu_exec_stage: RTL and testbench
=================================

# alu_exec_stage

Registered execute-stage ALU that consumes the 4-bit `alu_control` code produced by the ALU control decoder and operates on two XLEN-bit operands. Results are written into a 2-entry output buffer under a valid/ready handshake, so downstream stalls do not corrupt in-flight results. The block sits between operand read/decode and writeback/memory in the CPU datapath.

## Interface
- `XLEN`, 32, operand and result width.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  upstream presents a valid operation.
- `in_ready`  output  1  stage can accept an operation this cycle.
- `alu_control`  input  4  operation code from the ALU control decoder.
- `op_a`  input  XLEN  operand A.
- `op_b`  input  XLEN  operand B.
- `out_valid`  output  1  buffer head holds a valid result.
- `out_ready`  input  1  downstream consumes the head this cycle.
- `result`  output  XLEN  head result.
- `zero`  output  1  head result equals 0 (legal ops only).
- `illegal`  output  1  head op carried an unsupported code.

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Result computed combinationally from inputs that cycle, then pushed into the buffer.
- Pop: `out_valid && out_ready` at a rising edge removes the head.
- Codes:
  - 0000 AND: a & b
  - 0001 OR: a | b
  - 0010 ADD: a + b, mod 2^XLEN, carry discarded
  - 0110 SUB: a − b, mod 2^XLEN
  - 0111 SLT: signed two's-complement compare; result 1 if a < b, else 0, zero-extended to XLEN
  - 1100 NOR: ~(a | b)
- Any other code: stored result = 0, `illegal` = 1, `zero` = 0. The entry is still accepted and must be popped normally.
- Buffer: 2 entries (result, zero, illegal), FIFO order, occupancy count 0..2. Head read pointer and write pointer wrap modulo 2.
- `in_ready` = (count < 2). It depends only on registered count, with no combinational path from `out_ready`. When full, no accept occurs even if a pop happens the same cycle.
- Simultaneous push and pop with count 1: count stays 1, and the new entry becomes head after the old head leaves.
- `out_valid` = (count > 0). When count = 0, `result`, `zero` and `illegal` are driven 0.
- `rst` overrides everything in its cycle. It clears count and both pointers, and discards buffered entries. No accept or pop takes effect in a reset cycle.

## Timing
- Reset values: `in_ready`=1 (count 0), `out_valid`=0, `result`=0, `zero`=0, `illegal`=0.
- Latency: an op accepted at edge N is visible at the outputs (`out_valid`=1) after edge N if the buffer was empty. Otherwise it appears after the entries ahead of it are popped.
- Throughput: 1 op/cycle sustained when `out_ready` is held high.
- Outputs change only on rising edges. No combinational path exists from `in_*` to `out_*`.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid`=1. Required: `out_valid`=0, `in_ready`=1, `result`=0 throughout; no entry buffered after release.
- Arithmetic stream with `out_ready`=1:
  - ADD 5,7 → 12, zero=0
  - SUB 5,5 → 0, zero=1
  - SLT 0xFFFFFFFF,1 → 1
  - SLT 1,0xFFFFFFFF → 0
  - ADD 0xFFFFFFFF,1 → 0, zero=1
  - Each result appears one cycle after accept.
- Logic: AND 0xF0F0,0xFF00 → 0xF000; OR same → 0xFFF0; NOR 0,0 → 0xFFFFFFFF.
- Backpressure: `out_ready`=0, push ADD 1,1 then ADD 2,2. Required: `in_ready`=0, third op not accepted. Then `out_ready`=1: results 2 then 4 in order, and `in_ready` returns to 1 one edge after the first pop.
- Illegal code 0011 with a=3, b=4 → `result`=0, `illegal`=1, `zero`=0, popped normally; the next legal op has `illegal`=0.
- Reset mid-operation: buffer full, assert `rst` one cycle. Required: count=0 and `out_valid`=0 the next cycle; no stale result appears afterwards.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with a 2-entry result buffer.
// Results are queued so downstream stalls never drop in-flight ops.
module alu_exec_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            zero;
    logic            ill;
  } ent_t;

  ent_t       fifo_q [2];
  ent_t       alu_e;
  ent_t       head;
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       slt;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign slt       = $signed(op_a) < $signed(op_b);

  // Decode the op code and compute the entry to enqueue.
  always_comb begin
    alu_e = '0;
    unique case (alu_control)
      4'b0000: alu_e.res = op_a & op_b;
      4'b0001: alu_e.res = op_a | op_b;
      4'b0010: alu_e.res = op_a + op_b;
      4'b0110: alu_e.res = op_a - op_b;
      4'b0111: alu_e.res = {{(XLEN-1){1'b0}}, slt};
      4'b1100: alu_e.res = ~(op_a | op_b);
      default: alu_e.ill = 1'b1;
    endcase
    alu_e.zero = !alu_e.ill && (alu_e.res == '0);
  end

  // Pointer and occupancy bookkeeping; reset wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until counted valid.
  always_ff @(posedge clk) begin
    if (!rst && push) fifo_q[wr_ptr] <= alu_e;
  end

  // Head view, forced to zero when the buffer is empty.
  always_comb begin
    head = '0;
    if (out_valid) head = fifo_q[rd_ptr];
  end

  assign result  = head.res;
  assign zero    = head.zero;
  assign illegal = head.ill;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage: queue model checked each cycle
// plus directed vectors with hand-computed results.
module tb_alu_exec_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_control;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_control(alu_control),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] r;
    bit          z;
    bit          il;
  } ent_t;

  ent_t q[$];
  ent_t m_e;
  bit   m_acc;
  bit   m_pop;

  function automatic ent_t model_op(logic [3:0] c,
                                    logic [31:0] a,
                                    logic [31:0] b);
    ent_t e;
    e.r = 0;
    e.il = 0;
    case (c)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: e.r = a + b;
      4'b0110: e.r = a - b;
      4'b0111: e.r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b1100: e.r = ~(a | b);
      default: e.il = 1;
    endcase
    e.z = !e.il && (e.r == 0);
    return e;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state advances on the same edge the DUT samples.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_pop = (q.size() > 0) && out_ready;
      m_e   = model_op(alu_control, op_a, op_b);
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back(m_e);
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("m_result", result, q[0].r);
      chk("m_zero", {31'd0, zero}, {31'd0, q[0].z});
      chk("m_illegal", {31'd0, illegal}, {31'd0, q[0].il});
    end else begin
      chk("m_result_idle", result, 32'd0);
      chk("m_zero_idle", {31'd0, zero}, 32'd0);
      chk("m_illegal_idle", {31'd0, illegal}, 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    in_valid    = 1;
    alu_control = c;
    op_a        = a;
    op_b        = b;
    step();
  endtask

  task automatic expect_head(string nm, logic [31:0] r, bit z, bit il);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_result"}, result, r);
    chk({nm, "_zero"}, {31'd0, zero}, {31'd0, z});
    chk({nm, "_illegal"}, {31'd0, illegal}, {31'd0, il});
  endtask

  task automatic expect_empty(string nm);
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({nm, "_result"}, result, 32'd0);
  endtask

  initial begin
    rst         = 1;
    in_valid    = 1;
    alu_control = 4'b0010;
    op_a        = 32'd1;
    op_b        = 32'd1;
    out_ready   = 1;

    step();
    expect_empty("rst0");
    step();
    expect_empty("rst1");
    rst      = 0;
    in_valid = 0;
    step();
    expect_empty("post_rst");

    drive(4'b0010, 32'd5, 32'd7);
    expect_head("add5_7", 32'd12, 0, 0);
    drive(4'b0110, 32'd5, 32'd5);
    expect_head("sub5_5", 32'd0, 1, 0);
    drive(4'b0111, 32'hFFFF_FFFF, 32'd1);
    expect_head("slt_neg", 32'd1, 0, 0);
    drive(4'b0111, 32'd1, 32'hFFFF_FFFF);
    expect_head("slt_pos", 32'd0, 1, 0);
    drive(4'b0010, 32'hFFFF_FFFF, 32'd1);
    expect_head("add_wrap", 32'd0, 1, 0);
    drive(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
    expect_head("and", 32'h0000_F000, 0, 0);
    drive(4'b0001, 32'h0000_F0F0, 32'h0000_FF00);
    expect_head("or", 32'h0000_FFF0, 0, 0);
    drive(4'b1100, 32'd0, 32'd0);
    expect_head("nor", 32'hFFFF_FFFF, 0, 0);
    in_valid = 0;
    step();
    expect_empty("drain1");

    out_ready = 0;
    drive(4'b0010, 32'd1, 32'd1);
    expect_head("bp_first", 32'd2, 0, 0);
    drive(4'b0010, 32'd2, 32'd2);
    expect_head("bp_full", 32'd2, 0, 0);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    drive(4'b0010, 32'd3, 32'd3);
    expect_head("bp_third", 32'd2, 0, 0);
    chk("bp_in_ready2", {31'd0, in_ready}, 32'd0);
    in_valid  = 0;
    out_ready = 1;
    step();
    expect_head("bp_pop1", 32'd4, 0, 0);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    step();
    expect_empty("bp_drained");

    drive(4'b0011, 32'd3, 32'd4);
    expect_head("illegal", 32'd0, 0, 1);
    drive(4'b0010, 32'd0, 32'd0);
    expect_head("after_ill", 32'd0, 1, 0);
    in_valid = 0;
    step();
    expect_empty("drain2");

    out_ready = 0;
    drive(4'b0010, 32'd9, 32'd9);
    drive(4'b0001, 32'd1, 32'd2);
    expect_head("pre_rst", 32'd18, 0, 0);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    rst      = 1;
    in_valid = 1;
    step();
    expect_empty("mid_rst");
    rst       = 0;
    in_valid  = 0;
    out_ready = 1;
    step();
    expect_empty("post_rst1");
    step();
    expect_empty("post_rst2");

    for (int i = 0; i < 6; i++) begin
      drive(i[0] ? 4'b0110 : 4'b0010, 32'(i * 3), 32'(i + 1));
    end
    in_valid = 0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
